// File: rtl/silife_grid_reader.sv
// -----------------------------------------------------------------------------
// silife_grid_reader
//
// Snapshot readout engine for the SiLife cell array. On an accepted start the
// `out` bit of every cell is frozen in a single clock edge. The frozen image is
// then streamed row by row as bytes over a valid/ready interface while the live
// grid keeps evolving.
//
// Each row occupies ceil(WIDTH/8) bytes. Bit i of a byte is column
// (chunk*8 + i) of its row. Columns past WIDTH in the last chunk of a row read
// as zero.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-low reset; clears all state
//   start      snapshot request, honoured only while idle
//   cells      live cell states, bit index = row*WIDTH + col
//   busy       high while a frame is being streamed
//   out_valid  out_data holds a byte
//   out_ready  sink accepts the byte this cycle
//   out_data   eight packed cell bits
//   out_last   marks the final byte of a frame
// -----------------------------------------------------------------------------
module silife_grid_reader #(
    parameter int WIDTH  = 8,
    parameter int HEIGHT = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [WIDTH*HEIGHT-1:0]   cells,
    output logic                      busy,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [7:0]                out_data,
    output logic                      out_last
);

    localparam int BPR    = (WIDTH + 7) / 8;
    localparam int NBYTES = HEIGHT * BPR;
    localparam int KW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [KW-1:0] LAST_K = KW'(NBYTES - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t          state_reg;
    logic [KW-1:0]   k_reg;
    logic [7:0]      snapshot_reg [NBYTES];
    logic            armed_reg;
    logic            busy_reg;
    logic            out_valid_reg;
    logic            out_last_reg;

    // Live cells re-laid out so that every row starts on a byte boundary.
    // Padding columns are tied to zero, so the stored snapshot is already in
    // the exact byte order that is streamed.
    logic [NBYTES*8-1:0] cells_padded;

    genvar gi, gj;
    generate
        for (gi = 0; gi < HEIGHT; gi++) begin : g_row
            for (gj = 0; gj < BPR * 8; gj++) begin : g_col
                if (gj < WIDTH) begin : g_live
                    assign cells_padded[gi*BPR*8 + gj] = cells[gi*WIDTH + gj];
                end else begin : g_pad
                    assign cells_padded[gi*BPR*8 + gj] = 1'b0;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= IDLE;
            k_reg         <= '0;
            armed_reg     <= 1'b0;
            busy_reg      <= 1'b0;
            out_valid_reg <= 1'b0;
            out_last_reg  <= 1'b0;
            for (int j = 0; j < NBYTES; j++) begin
                snapshot_reg[j] <= 8'h00;
            end
        end else begin
            // armed_reg keeps a start that coincides with the first edge after
            // reset release from being honoured.
            armed_reg <= 1'b1;
            case (state_reg)
                IDLE: begin
                    if (start && armed_reg) begin
                        for (int j = 0; j < NBYTES; j++) begin
                            snapshot_reg[j] <= cells_padded[j*8 +: 8];
                        end
                        k_reg         <= '0;
                        state_reg     <= SEND;
                        busy_reg      <= 1'b1;
                        out_valid_reg <= 1'b1;
                        out_last_reg  <= (NBYTES == 1);
                    end
                end
                SEND: begin
                    // start is deliberately not looked at here: it is neither
                    // honoured nor remembered while a frame is in flight.
                    if (out_ready) begin
                        if (k_reg == LAST_K) begin
                            state_reg     <= IDLE;
                            busy_reg      <= 1'b0;
                            out_valid_reg <= 1'b0;
                            out_last_reg  <= 1'b0;
                        end else begin
                            k_reg        <= k_reg + KW'(1);
                            out_last_reg <= ((k_reg + KW'(1)) == LAST_K);
                        end
                    end
                end
                default: begin
                    state_reg     <= IDLE;
                    busy_reg      <= 1'b0;
                    out_valid_reg <= 1'b0;
                    out_last_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = busy_reg;
    assign out_valid = out_valid_reg;
    assign out_last  = out_last_reg;
    // Decoded only from registers; forced to zero whenever no byte is offered,
    // which also makes it drop to zero the moment reset is asserted.
    assign out_data  = out_valid_reg ? snapshot_reg[k_reg] : 8'h00;

endmodule

// File: tb/tb_silife_grid_reader.sv
// -----------------------------------------------------------------------------
// tb_silife_grid_reader
//
// Two instances share clock, reset, start and out_ready: an 8x8 grid (dut 0)
// and a 10x2 grid with row padding (dut 1). A behavioural model tracks, per
// instance, whether a frame is in flight, which byte is offered and the frozen
// picture, and derives each byte from row/column arithmetic. Outputs are
// compared every cycle; accepted bytes are also recorded for literal checks.
// -----------------------------------------------------------------------------
module tb_silife_grid_reader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        out_ready = 1'b0;
    logic [63:0] cells0 = '0;
    logic [19:0] cells1 = '1;

    logic        busy0, valid0, last0;
    logic [7:0]  data0;
    logic        busy1, valid1, last1;
    logic [7:0]  data1;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    silife_grid_reader #(.WIDTH(8), .HEIGHT(8)) u_dut0 (
        .clk(clk), .reset(rst_n), .start(start), .cells(cells0),
        .busy(busy0), .out_valid(valid0), .out_ready(out_ready),
        .out_data(data0), .out_last(last0)
    );

    silife_grid_reader #(.WIDTH(10), .HEIGHT(2)) u_dut1 (
        .clk(clk), .reset(rst_n), .start(start), .cells(cells1),
        .busy(busy1), .out_valid(valid1), .out_ready(out_ready),
        .out_data(data1), .out_last(last1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    function automatic int wd(input int d);
        return (d == 0) ? 8 : 10;
    endfunction
    function automatic int nbytes(input int d);
        return (d == 0) ? 8 * ((8 + 7) / 8) : 2 * ((10 + 7) / 8);
    endfunction
    function automatic logic [7:0] byte_of(input logic [127:0] s, input int k, input int w);
        int bpr, r, b;
        logic [7:0] v;
        bpr = (w + 7) / 8;
        r = k / bpr;
        b = k % bpr;
        v = 8'h00;
        for (int i = 0; i < 8; i++)
            if (b * 8 + i < w) v[i] = s[r * w + b * 8 + i];
        return v;
    endfunction

    bit           m_active [2];
    int           m_k      [2];
    logic [127:0] m_snap   [2];
    bit           m_armed;
    logic [7:0]   rec0[$];
    logic         rec0_last[$];
    logic [7:0]   rec1[$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int d = 0; d < 2; d++) begin
                m_active[d] = 1'b0;
                m_k[d] = 0;
                m_snap[d] = '0;
            end
            m_armed = 1'b0;
        end else begin
            if (valid0 && out_ready) begin
                rec0.push_back(data0);
                rec0_last.push_back(last0);
            end
            if (valid1 && out_ready) rec1.push_back(data1);
            for (int d = 0; d < 2; d++) begin
                if (!m_active[d]) begin
                    if (start && m_armed) begin
                        m_active[d] = 1'b1;
                        m_k[d] = 0;
                        m_snap[d] = (d == 0) ? {64'b0, cells0} : {108'b0, cells1};
                    end
                end else if (out_ready) begin
                    if (m_k[d] == nbytes(d) - 1) m_active[d] = 1'b0;
                    else m_k[d]++;
                end
            end
            m_armed = 1'b1;
        end
    end

    // Per-cycle comparison of both instances against the model.
    always @(posedge clk) begin
        #1;
        if (rst_n) begin
            chk("busy0",  {31'b0, busy0},  {31'b0, m_active[0]});
            chk("valid0", {31'b0, valid0}, {31'b0, m_active[0]});
            chk("last0",  {31'b0, last0},  {31'b0, m_active[0] && m_k[0] == nbytes(0) - 1});
            chk("data0",  {24'b0, data0},
                {24'b0, m_active[0] ? byte_of(m_snap[0], m_k[0], wd(0)) : 8'h00});
            chk("busy1",  {31'b0, busy1},  {31'b0, m_active[1]});
            chk("valid1", {31'b0, valid1}, {31'b0, m_active[1]});
            chk("last1",  {31'b0, last1},  {31'b0, m_active[1] && m_k[1] == nbytes(1) - 1});
            chk("data1",  {24'b0, data1},
                {24'b0, m_active[1] ? byte_of(m_snap[1], m_k[1], wd(1)) : 8'h00});
        end
    end

    // ---------------- stimulus helpers ----------------
    function automatic logic ready_for(input int mode, input int c);
        if (mode == 0) return 1'b1;
        if (mode == 1) return (c % 3 == 0);
        return 1'($urandom_range(0, 1));
    endfunction

    // Launch one frame and drain both instances. mode: 0 ready=1, 1 toggling
    // 1,0,0, 2 random. invert flips cells0 every cycle; hold keeps start high
    // while dut 0 streams (including its last handshake).
    task automatic run_frame(input logic [63:0] pat, input int mode, input bit invert, input bit hold);
        int c;
        rec0.delete(); rec0_last.delete(); rec1.delete();
        @(negedge clk);
        cells0 = pat;
        start = 1'b1;
        out_ready = ready_for(mode, 0);
        c = 0;
        do begin
            @(negedge clk);
            c++;
            start = hold && m_active[0];
            if (invert) cells0 = ~cells0;
            out_ready = ready_for(mode, c);
        end while ((m_active[0] || m_active[1]) && c < 400);
        chk("frame_timeout", {31'b0, m_active[0] || m_active[1]}, 32'd0);
        start = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] pat;
        logic [7:0] exp_glider [8];
        logic [7:0] exp_pad [4];
        int nlast;
        exp_glider = '{8'h02, 8'h04, 8'h07, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        exp_pad    = '{8'hFF, 8'h03, 8'hFF, 8'h03};

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_busy0",  {31'b0, busy0},  32'd0);
        chk("rst_valid0", {31'b0, valid0}, 32'd0);
        chk("rst_last0",  {31'b0, last0},  32'd0);
        chk("rst_data0",  {24'b0, data0},  32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Glider on 8x8; all-ones on 10x2
        pat = '0;
        pat[1] = 1'b1; pat[10] = 1'b1; pat[16] = 1'b1; pat[17] = 1'b1; pat[18] = 1'b1;
        run_frame(pat, 0, 1'b0, 1'b0);
        chk("glider_count", rec0.size(), 32'd8);
        nlast = 0;
        for (int i = 0; i < rec0.size() && i < 8; i++) begin
            chk($sformatf("glider_byte%0d", i), {24'b0, rec0[i]}, {24'b0, exp_glider[i]});
            nlast += int'(rec0_last[i]);
        end
        chk("glider_nlast", nlast, 32'd1);
        if (rec0_last.size() == 8) chk("glider_last7", {31'b0, rec0_last[7]}, 32'd1);
        chk("pad_count", rec1.size(), 32'd4);
        for (int i = 0; i < rec1.size() && i < 4; i++)
            chk($sformatf("pad_byte%0d", i), {24'b0, rec1[i]}, {24'b0, exp_pad[i]});
        chk("glider_idle_busy", {31'b0, busy0}, 32'd0);

        // Snapshot freeze while cells toggle every cycle
        pat = {$urandom, $urandom};
        run_frame(pat, 0, 1'b1, 1'b0);
        chk("freeze_count", rec0.size(), 32'd8);
        for (int i = 0; i < rec0.size() && i < 8; i++)
            chk($sformatf("freeze_byte%0d", i), {24'b0, rec0[i]}, {24'b0, pat[i*8 +: 8]});

        // Backpressure 1,0,0,...
        pat = {$urandom, $urandom};
        run_frame(pat, 1, 1'b0, 1'b0);
        chk("bp_count", rec0.size(), 32'd8);
        for (int i = 0; i < rec0.size() && i < 8; i++)
            chk($sformatf("bp_byte%0d", i), {24'b0, rec0[i]}, {24'b0, pat[i*8 +: 8]});

        // start held through the whole frame including the last handshake
        pat = {$urandom, $urandom};
        run_frame(pat, 0, 1'b0, 1'b1);
        chk("hold_one_frame", rec0.size(), 32'd8);
        chk("hold_idle", {31'b0, busy0}, 32'd0);

        // Back-to-back: start still high one cycle after the last handshake
        rec0.delete(); rec0_last.delete();
        @(negedge clk);
        cells0 = 64'h0123_4567_89AB_CDEF;
        start = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 50 && !(rec0.size() == 8 && !m_active[0]); c++) @(negedge clk);
        @(negedge clk);
        chk("b2b_relaunch", {31'b0, busy0}, 32'd1);
        start = 1'b0;
        for (int c = 0; c < 50 && (m_active[0] || m_active[1]); c++) @(negedge clk);
        chk("b2b_drained", {31'b0, busy0 || busy1}, 32'd0);

        // Reset in the middle of a frame
        pat = {$urandom, $urandom};
        rec0.delete(); rec0_last.delete();
        @(negedge clk);
        cells0 = pat;
        start = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        out_ready = 1'b0;
        @(negedge clk);
        chk("mid_count", rec0.size(), 32'd3);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", {31'b0, valid0}, 32'd0);
        chk("mid_rst_busy",  {31'b0, busy0},  32'd0);
        chk("mid_rst_last",  {31'b0, last0},  32'd0);
        chk("mid_rst_data",  {24'b0, data0},  32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        pat = {$urandom, $urandom};
        run_frame(pat, 0, 1'b0, 1'b0);
        chk("post_rst_count", rec0.size(), 32'd8);
        for (int i = 0; i < rec0.size() && i < 8; i++)
            chk($sformatf("post_rst_byte%0d", i), {24'b0, rec0[i]}, {24'b0, pat[i*8 +: 8]});

        // Randomised frames
        for (int n = 0; n < 20; n++) begin
            pat = {$urandom, $urandom};
            cells1 = 20'($urandom);
            run_frame(pat, int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)));
            chk($sformatf("rand_count%0d", n), rec0.size(), 32'd8);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        do_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
